// File: rtl/mb_pkg.sv
// Shared types and constants for the math box host interface.
// Contents: FSM state enum, status byte bit positions, timeout result fill value.
package mb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StRun,
        StDone
    } mb_state_e;

    localparam int unsigned BUSY_BIT    = 7;
    localparam int unsigned TIMEOUT_BIT = 6;

    // Value loaded into the result register when the watchdog gives up.
    localparam logic [15:0] TIMEOUT_FILL = 16'hFFFF;

endpackage

// File: rtl/mb_host_iface_if.sv
// Bus bundle between the CPU / math box environment and mb_host_iface.
// CPU side:      MB_WR, MB_ADDR, MB_DIN, STAT_RD, RESLO_RD, RESHI_RD -> ; <- CPU_DOUT
// Math box side: <- BEGIN_N, START_ADDR, OPERAND ; STOP, RESULT ->
// Status:        <- BUSY
// Modports: slave  = the host interface block itself
//           master = the environment (CPU + math box sequencer)
interface mb_host_iface_if;

    logic        MB_WR;
    logic [4:0]  MB_ADDR;
    logic [7:0]  MB_DIN;
    logic        STAT_RD;
    logic        RESLO_RD;
    logic        RESHI_RD;
    logic [7:0]  CPU_DOUT;
    logic        BEGIN_N;
    logic [4:0]  START_ADDR;
    logic [7:0]  OPERAND;
    logic        STOP;
    logic [15:0] RESULT;
    logic        BUSY;

    modport slave (
        input  MB_WR, MB_ADDR, MB_DIN, STAT_RD, RESLO_RD, RESHI_RD, STOP, RESULT,
        output CPU_DOUT, BEGIN_N, START_ADDR, OPERAND, BUSY
    );

    modport master (
        output MB_WR, MB_ADDR, MB_DIN, STAT_RD, RESLO_RD, RESHI_RD, STOP, RESULT,
        input  CPU_DOUT, BEGIN_N, START_ADDR, OPERAND, BUSY
    );

endinterface

// File: rtl/mb_watchdog.sv
// Run-time watchdog for the math box host interface.
// A clear/enable up-counter; tc_o flags the last permitted cycle (count == LIMIT-1)
// while enabled, so the owner can act on the edge that ends the LIMIT-th cycle.
// Ports: clk_i, rst_i (sync, active-high), clr_i, en_i -> tc_o
module mb_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned     CntW    = $clog2(LIMIT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(LIMIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            // Saturate at the terminal count.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mb_host_iface.sv
// CPU-side host interface for the math box sequencer.
// A CPU write latches start address and operand and issues a BEGIN_N low pulse of
// BEGIN_CYCLES cycles; the block then waits for STOP, latches RESULT and reports
// status. CPU reads return status / result low / result high one cycle after the strobe.
// Ports: CLK, RESET (sync, active-high), bus (mb_host_iface_if.slave)
// Optional feature: define MB_HOST_TIMEOUT_EN to add a RUN watchdog of TIMEOUT_CYCLES
// cycles that ends the computation with TIMEOUT set and a result of 16'hFFFF.
module mb_host_iface
    import mb_pkg::*;
#(
    parameter int unsigned BEGIN_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic           CLK,
    input  logic           RESET,
    mb_host_iface_if.slave bus
);

    localparam logic [3:0] PulseLast = 4'(BEGIN_CYCLES - 1);

    mb_state_e   state_q, state_d;
    logic        begin_n_q, begin_n_d;
    logic        busy_q, busy_d;
    logic [4:0]  start_addr_q, start_addr_d;
    logic [7:0]  operand_q, operand_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d;
    logic [3:0]  pulse_cnt_q, pulse_cnt_d;
    logic        timeout_flag;
    logic [7:0]  status;

`ifdef MB_HOST_TIMEOUT_EN
    logic timeout_q, timeout_d;
    logic wd_tc;

    mb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i (CLK),
        .rst_i (RESET),
        .clr_i (state_q != StRun),
        .en_i  (state_q == StRun),
        .tc_o  (wd_tc)
    );

    assign timeout_flag = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_flag       = 1'b0;
`endif

    always_comb begin
        status              = '0;
        status[BUSY_BIT]    = busy_q;
        status[TIMEOUT_BIT] = timeout_flag;
    end

    always_comb begin
        state_d      = state_q;
        begin_n_d    = begin_n_q;
        busy_d       = busy_q;
        start_addr_d = start_addr_q;
        operand_d    = operand_q;
        result_d     = result_q;
        pulse_cnt_d  = pulse_cnt_q;
        cpu_dout_d   = cpu_dout_q;
`ifdef MB_HOST_TIMEOUT_EN
        timeout_d    = timeout_q;
`endif

        // Read path: priority STAT > RESLO > RESHI, hold otherwise.
        if (bus.STAT_RD) begin
            cpu_dout_d = status;
        end else if (bus.RESLO_RD) begin
            cpu_dout_d = result_q[7:0];
        end else if (bus.RESHI_RD) begin
            cpu_dout_d = result_q[15:8];
        end

        // A write restarts from any state and beats a simultaneous STOP.
        if (bus.MB_WR) begin
            start_addr_d = bus.MB_ADDR;
            operand_d    = bus.MB_DIN;
            state_d      = StStart;
            begin_n_d    = 1'b0;
            busy_d       = 1'b1;
            pulse_cnt_d  = '0;
`ifdef MB_HOST_TIMEOUT_EN
            timeout_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                // STOP is not looked at here: the sequencer is held clear.
                StStart: begin
                    if (pulse_cnt_q == PulseLast) begin
                        state_d     = StRun;
                        begin_n_d   = 1'b1;
                        pulse_cnt_d = '0;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + 4'd1;
                    end
                end
                StRun: begin
                    if (bus.STOP) begin
                        result_d = bus.RESULT;
                        state_d  = StDone;
                        busy_d   = 1'b0;
`ifdef MB_HOST_TIMEOUT_EN
                    end else if (wd_tc) begin
                        timeout_d = 1'b1;
                        result_d  = TIMEOUT_FILL;
                        state_d   = StDone;
                        busy_d    = 1'b0;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= StIdle;
            begin_n_q    <= 1'b1;
            busy_q       <= 1'b0;
            start_addr_q <= '0;
            operand_q    <= '0;
            result_q     <= '0;
            cpu_dout_q   <= '0;
            pulse_cnt_q  <= '0;
`ifdef MB_HOST_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            begin_n_q    <= begin_n_d;
            busy_q       <= busy_d;
            start_addr_q <= start_addr_d;
            operand_q    <= operand_d;
            result_q     <= result_d;
            cpu_dout_q   <= cpu_dout_d;
            pulse_cnt_q  <= pulse_cnt_d;
`ifdef MB_HOST_TIMEOUT_EN
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign bus.CPU_DOUT   = cpu_dout_q;
    assign bus.BEGIN_N    = begin_n_q;
    assign bus.START_ADDR = start_addr_q;
    assign bus.OPERAND    = operand_q;
    assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_mb_host_iface.sv
// Self-checking bench for mb_host_iface: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the host interface.
module tb_mb_host_iface;

    localparam int BC = 2;
    localparam int TO = 16;
`ifdef MB_HOST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mb_host_iface_if bus ();

    mb_host_iface #(
        .BEGIN_CYCLES   (BC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: a computation is "active" from the write until STOP/timeout;
    // m_age counts edges since the write, the first BC of which are the BEGIN_N pulse.
    bit          m_active;
    int          m_age;
    bit          m_timeout;
    logic [15:0] m_result;
    logic [4:0]  m_addr;
    logic [7:0]  m_op;
    logic [7:0]  m_dout;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [7:0] st;
        if (rst) begin
            m_active = 1'b0; m_age = 0; m_timeout = 1'b0;
            m_result = '0; m_addr = '0; m_op = '0; m_dout = '0;
            return;
        end
        st = {m_active, m_timeout, 6'b0};
        if (bus.STAT_RD)       m_dout = st;
        else if (bus.RESLO_RD) m_dout = m_result[7:0];
        else if (bus.RESHI_RD) m_dout = m_result[15:8];
        if (bus.MB_WR) begin
            m_active = 1'b1; m_age = 0; m_timeout = 1'b0;
            m_addr = bus.MB_ADDR; m_op = bus.MB_DIN;
        end else if (m_active) begin
            if (m_age >= BC && bus.STOP) begin
                m_result = bus.RESULT; m_active = 1'b0;
            end else if (TO_EN && m_age >= BC && (m_age - BC) == TO - 1) begin
                m_timeout = 1'b1; m_result = 16'hFFFF; m_active = 1'b0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic compare_all();
        check("m_busy", bus.BUSY, m_active);
        check("m_begin_n", bus.BEGIN_N, !(m_active && m_age < BC));
        check("m_start_addr", bus.START_ADDR, m_addr);
        check("m_operand", bus.OPERAND, m_op);
        check("m_cpu_dout", bus.CPU_DOUT, m_dout);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic clr_in();
        bus.MB_WR = 1'b0; bus.STOP = 1'b0;
        bus.STAT_RD = 1'b0; bus.RESLO_RD = 1'b0; bus.RESHI_RD = 1'b0;
    endtask

    task automatic rd(input bit s, input bit lo, input bit hi);
        bus.STAT_RD = s; bus.RESLO_RD = lo; bus.RESHI_RD = hi;
        step();
        clr_in();
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus.MB_ADDR = a; bus.MB_DIN = d; bus.MB_WR = 1'b1;
        step();
        clr_in();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] r;
        rst = 1'b1;
        clr_in();
        bus.MB_ADDR = '0; bus.MB_DIN = '0; bus.RESULT = '0;

        // Reset state
        step(); step();
        rst = 1'b0;
        check("rst_begin_n", bus.BEGIN_N, 1'b1);
        check("rst_busy", bus.BUSY, 1'b0);
        check("rst_start_addr", bus.START_ADDR, 5'h00);
        check("rst_operand", bus.OPERAND, 8'h00);
        check("rst_dout", bus.CPU_DOUT, 8'h00);
        rd(1'b0, 1'b0, 1'b1);
        check("rst_reshi", bus.CPU_DOUT, 8'h00);

        // Basic start: two-cycle BEGIN_N pulse
        wr(5'h0A, 8'h3C);
        check("start_addr", bus.START_ADDR, 5'h0A);
        check("start_operand", bus.OPERAND, 8'h3C);
        check("start_begin_n_1", bus.BEGIN_N, 1'b0);
        check("start_busy", bus.BUSY, 1'b1);
        step();
        check("start_begin_n_2", bus.BEGIN_N, 1'b0);
        step();
        check("start_begin_n_end", bus.BEGIN_N, 1'b1);
        check("run_busy", bus.BUSY, 1'b1);

        // Completion at RUN cycle 10
        bus.RESULT = 16'h1234;
        repeat (9) step();
        check("run_busy_c10", bus.BUSY, 1'b1);
        bus.STOP = 1'b1;
        step();
        clr_in();
        check("done_busy", bus.BUSY, 1'b0);
        rd(1'b1, 1'b0, 1'b0);
        check("done_stat", bus.CPU_DOUT, 8'h00);
        rd(1'b0, 1'b1, 1'b0);
        check("done_reslo", bus.CPU_DOUT, 8'h34);
        rd(1'b0, 1'b0, 1'b1);
        check("done_reshi", bus.CPU_DOUT, 8'h12);
        step();
        check("dout_hold", bus.CPU_DOUT, 8'h12);
        rd(1'b0, 1'b1, 1'b1);
        check("prio_lo_hi", bus.CPU_DOUT, 8'h34);
        rd(1'b1, 1'b1, 1'b1);
        check("prio_all", bus.CPU_DOUT, 8'h00);

        // Restart: write beats STOP in RUN
        wr(5'h15, 8'h77);
        step(); step();
        bus.RESULT = 16'hABCD; bus.STOP = 1'b1;
        wr(5'h1F, 8'hE1);
        check("restart_addr", bus.START_ADDR, 5'h1F);
        check("restart_operand", bus.OPERAND, 8'hE1);
        check("restart_begin_n", bus.BEGIN_N, 1'b0);
        rd(1'b1, 1'b0, 1'b0);
        check("restart_stat", bus.CPU_DOUT, 8'h80);
        check("restart_begin_n_2", bus.BEGIN_N, 1'b0);
        rd(1'b0, 1'b1, 1'b0);
        check("restart_pulse_end", bus.BEGIN_N, 1'b1);
        check("restart_result_kept", bus.CPU_DOUT, 8'h34);
        bus.RESULT = 16'h5678; bus.STOP = 1'b1;
        step();
        clr_in();
        rd(1'b0, 1'b0, 1'b1);
        check("restart_reshi", bus.CPU_DOUT, 8'h56);

`ifdef MB_HOST_TIMEOUT_EN
        // Watchdog expiry after 16 RUN cycles
        wr(5'h03, 8'h01);
        step(); step();
        repeat (15) step();
        check("to_busy_c15", bus.BUSY, 1'b1);
        step();
        check("to_done", bus.BUSY, 1'b0);
        rd(1'b1, 1'b0, 1'b0);
        check("to_stat", bus.CPU_DOUT, 8'h40);
        rd(1'b0, 1'b1, 1'b0);
        check("to_reslo", bus.CPU_DOUT, 8'hFF);
        rd(1'b0, 1'b0, 1'b1);
        check("to_reshi", bus.CPU_DOUT, 8'hFF);
        // Write clears TIMEOUT; STOP on the expiry cycle wins
        wr(5'h04, 8'h02);
        rd(1'b1, 1'b0, 1'b0);
        check("to_cleared_stat", bus.CPU_DOUT, 8'h80);
        step();
        repeat (15) step();
        bus.RESULT = 16'h0BEE; bus.STOP = 1'b1;
        step();
        clr_in();
        check("to_stop_wins_busy", bus.BUSY, 1'b0);
        rd(1'b1, 1'b0, 1'b0);
        check("to_stop_wins_stat", bus.CPU_DOUT, 8'h00);
        rd(1'b0, 1'b1, 1'b0);
        check("to_stop_wins_reslo", bus.CPU_DOUT, 8'hEE);
`else
        // Without the watchdog, RUN waits for STOP indefinitely
        wr(5'h03, 8'h01);
        step(); step();
        repeat (40) step();
        check("nowd_busy", bus.BUSY, 1'b1);
        rd(1'b1, 1'b0, 1'b0);
        check("nowd_stat", bus.CPU_DOUT, 8'h80);
        bus.RESULT = 16'h0BEE; bus.STOP = 1'b1;
        step();
        clr_in();
        rd(1'b1, 1'b0, 1'b0);
        check("nowd_done_stat", bus.CPU_DOUT, 8'h00);
        rd(1'b0, 1'b1, 1'b0);
        check("nowd_reslo", bus.CPU_DOUT, 8'hEE);
`endif

        // Reset during the BEGIN_N pulse
        wr(5'h11, 8'h22);
        check("mid_begin_n", bus.BEGIN_N, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_begin_n", bus.BEGIN_N, 1'b1);
        check("mid_rst_busy", bus.BUSY, 1'b0);
        check("mid_rst_addr", bus.START_ADDR, 5'h00);
        check("mid_rst_operand", bus.OPERAND, 8'h00);
        check("mid_rst_dout", bus.CPU_DOUT, 8'h00);
        bus.RESULT = 16'h9999; bus.STOP = 1'b1;
        step();
        clr_in();
        check("idle_stop_busy", bus.BUSY, 1'b0);
        rd(1'b0, 1'b1, 1'b0);
        check("idle_stop_reslo", bus.CPU_DOUT, 8'h00);
        rd(1'b0, 1'b0, 1'b1);
        check("idle_stop_reshi", bus.CPU_DOUT, 8'h00);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            bus.MB_WR    = ($urandom_range(0, 39) == 0);
            bus.MB_ADDR  = 5'($urandom);
            bus.MB_DIN   = 8'($urandom);
            bus.STOP     = ($urandom_range(0, 14) == 0);
            bus.RESULT   = 16'($urandom);
            r            = 3'($urandom);
            if ($urandom_range(0, 2) != 0) r = 3'b000;
            bus.STAT_RD  = r[0];
            bus.RESLO_RD = r[1];
            bus.RESHI_RD = r[2];
            step();
        end
        rst = 1'b0;
        clr_in();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
